launch_sequencer: RTL

LAUNCH_SEQUENCER -- requirements
Module: launch_sequencer

---
 rtl/launch_seq_pkg.sv | 24 ++
 rtl/launch_sequencer_debouncer.sv | 80 ++++++++
 rtl/launch_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/launch_seq_pkg.sv
// -----------------------------------------------------------------------------
// launch_seq_pkg
//   Shared definitions for the launch sequencer: FSM state encodings, default
//   timing parameters and the internal counter width.
// -----------------------------------------------------------------------------
package launch_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_COUNTDOWN = 3'd2,
    ST_FIRE      = 3'd3,
    ST_LOCKOUT   = 3'd4
  } state_t;

  localparam int CNT_W = 32;

  localparam int DEF_CLK_HZ          = 50_000_000;
  localparam int DEF_DEBOUNCE_CYCLES = 50_000;
  localparam int DEF_SECOND_CYCLES   = 50_000_000;
  localparam int DEF_COUNT_SECONDS   = 3;
  localparam int DEF_LOCKOUT_CYCLES  = 50_000_000;

endpackage

// File: rtl/launch_sequencer_debouncer.sv
// -----------------------------------------------------------------------------
// debouncer
//   Two-flop synchronizer followed by a run-length debouncer for one
//   asynchronous switch/button level.
//
// Ports
//   clock    in   system clock, rising edge
//   resetn   in   asynchronous active-low reset
//   din      in   raw asynchronous level
//   level    out  debounced level; changes only after DEBOUNCE_CYCLES
//                 consecutive synchronized samples of the new value
//   low_seen out  sticky: set once the input has been confirmed low for a full
//                 debounce window since reset (lets the caller reject a switch
//                 that was already on when reset was released)
// -----------------------------------------------------------------------------
module debouncer
  import launch_seq_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic resetn,
  input  logic din,
  output logic level,
  output logic low_seen
);

  localparam logic [CNT_W-1:0] TARGET = CNT_W'(DEBOUNCE_CYCLES);

  logic             sync1, sync2;
  logic             fill1, fill2;
  logic             prev, prev_ok;
  logic [CNT_W-1:0] run, run_cur;
  logic             stable;

  // Length of the run of identical synchronized samples ending at the current
  // sample. The fill flags keep the reset zeros in the synchronizer from being
  // counted as a genuine low reading.
  always_comb begin
    run_cur = '0;
    if (fill2) begin
      if (prev_ok && (sync2 == prev)) begin
        run_cur = (run >= TARGET) ? run : run + 1'b1;
      end else begin
        run_cur = {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign stable = fill2 && (run_cur >= TARGET);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      fill1    <= 1'b0;
      fill2    <= 1'b0;
      prev     <= 1'b0;
      prev_ok  <= 1'b0;
      run      <= '0;
      level    <= 1'b0;
      low_seen <= 1'b0;
    end else begin
      sync1   <= din;
      sync2   <= sync1;
      fill1   <= 1'b1;
      fill2   <= fill1;
      prev    <= sync2;
      prev_ok <= fill2;
      run     <= run_cur;
      if (stable) begin
        level <= sync2;
        if (!sync2) begin
          low_seen <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/launch_sequencer.sv
// -----------------------------------------------------------------------------
// launch_sequencer
//   Arm / fire / countdown / lockout sequencer producing a single-cycle fire
//   pulse for the downstream arm PWM controller.
//
// Ports
//   clock          in   system clock, rising edge
//   resetn         in   asynchronous active-low reset
//   arm_sw         in   raw arm key switch level (synchronized + debounced)
//   fire_btn       in   raw fire pushbutton level (synchronized + debounced)
//   abort          in   raw abort request level (synchronized only)
//   enable         out  one-cycle fire pulse, high only in FIRE
//   state          out  current FSM state code
//   countdown_sec  out  remaining whole seconds during COUNTDOWN, else 0
//   busy           out  high in COUNTDOWN, FIRE and LOCKOUT
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module launch_sequencer
  import launch_seq_pkg::*;
#(
  parameter int CLK_HZ          = DEF_CLK_HZ,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int SECOND_CYCLES   = DEF_SECOND_CYCLES,
  parameter int COUNT_SECONDS   = DEF_COUNT_SECONDS,
  parameter int LOCKOUT_CYCLES  = DEF_LOCKOUT_CYCLES
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       arm_sw,
  input  logic       fire_btn,
  input  logic       abort,
  output logic       enable,
  output logic [2:0] state,
  output logic [3:0] countdown_sec,
  output logic       busy
);

  localparam logic [CNT_W-1:0] SEC_LAST = CNT_W'(SECOND_CYCLES - 1);
  localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(COUNT_SECONDS * SECOND_CYCLES - 1);
  localparam logic [CNT_W-1:0] LO_LAST  = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0]       CD_LOAD  = 4'(COUNT_SECONDS);

  // CLK_HZ only documents the clock the timing parameters were derived from.
  logic unused_clk_hz;
  assign unused_clk_hz = (CLK_HZ > 0);

  logic arm_db, fire_db, arm_low_seen, fire_low_unused;
  logic abort_s1, abort_s2;
  logic arm_prev, fire_prev;
  logic arm_rise, fire_rise;

  state_t           st;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] sec_cnt;

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_arm_db (
    .clock    (clock),
    .resetn   (resetn),
    .din      (arm_sw),
    .level    (arm_db),
    .low_seen (arm_low_seen)
  );

  debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_fire_db (
    .clock    (clock),
    .resetn   (resetn),
    .din      (fire_btn),
    .level    (fire_db),
    .low_seen (fire_low_unused)
  );

  // Abort bypasses debouncing so it takes effect as soon as it is synchronized.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      abort_s1 <= 1'b0;
      abort_s2 <= 1'b0;
    end else begin
      abort_s1 <= abort;
      abort_s2 <= abort_s1;
    end
  end

  // An arm edge only counts once the switch has been seen off since reset, so a
  // key left on through reset cannot arm the system by itself.
  assign arm_rise  = arm_db && !arm_prev && arm_low_seen;
  assign fire_rise = fire_db && !fire_prev;

  assign state = st;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      st            <= ST_IDLE;
      enable        <= 1'b0;
      busy          <= 1'b0;
      countdown_sec <= '0;
      cnt           <= '0;
      sec_cnt       <= '0;
      arm_prev      <= 1'b0;
      fire_prev     <= 1'b0;
    end else begin
      arm_prev  <= arm_db;
      fire_prev <= fire_db;
      enable    <= 1'b0;

      case (st)
        ST_IDLE: begin
          if (arm_rise) begin
            st      <= ST_ARMED;
            cnt     <= '0;
            sec_cnt <= '0;
          end
        end

        ST_ARMED: begin
          if (!arm_db) begin
            st      <= ST_IDLE;
            cnt     <= '0;
            sec_cnt <= '0;
          end else if (fire_rise) begin
            st            <= ST_COUNTDOWN;
            busy          <= 1'b1;
            countdown_sec <= CD_LOAD;
            cnt           <= '0;
            sec_cnt       <= '0;
          end
        end

        // Abort beats arm-off, which beats the terminal count: an abort landing
        // on the last countdown cycle returns to IDLE without a fire pulse.
        ST_COUNTDOWN: begin
          if (abort_s2 || !arm_db) begin
            st            <= ST_IDLE;
            busy          <= 1'b0;
            countdown_sec <= '0;
            cnt           <= '0;
            sec_cnt       <= '0;
          end else if (cnt == CD_LAST) begin
            st            <= ST_FIRE;
            enable        <= 1'b1;
            countdown_sec <= '0;
            cnt           <= '0;
            sec_cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
            if (sec_cnt == SEC_LAST) begin
              sec_cnt       <= '0;
              countdown_sec <= countdown_sec - 4'd1;
            end else begin
              sec_cnt <= sec_cnt + 1'b1;
            end
          end
        end

        ST_FIRE: begin
          st      <= ST_LOCKOUT;
          cnt     <= '0;
          sec_cnt <= '0;
        end

        // Fire and abort are deliberately ignored until the actuator cycle ends.
        ST_LOCKOUT: begin
          if (cnt == LO_LAST) begin
            st      <= ST_IDLE;
            busy    <= 1'b0;
            cnt     <= '0;
            sec_cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: begin
          st            <= ST_IDLE;
          busy          <= 1'b0;
          countdown_sec <= '0;
          cnt           <= '0;
          sec_cnt       <= '0;
        end
      endcase
    end
  end

endmodule
